// File: rtl/hash_mem_stream_if.sv
// SHAKE front-end: streams a RAM-resident message into a Keccak/SHAKE core and
// forwards the digest to a valid/ready consumer, masking unused bits of the final words.
module hash_mem_stream_if #(
  parameter int IO_WIDTH      = 32,
  parameter int MAX_RAM_DEPTH = 128,
  parameter int LEN_WIDTH     = 32,
  localparam int ADDR_W = $clog2(MAX_RAM_DEPTH),
  localparam int BITS_W = $clog2(IO_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic [ADDR_W-1:0]    i_base_addr,
  input  logic [LEN_WIDTH-1:0] i_input_length,
  input  logic [LEN_WIDTH-1:0] i_output_length,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_addr,
  input  logic [IO_WIDTH-1:0]  i_data_in,
  output logic                 o_core_mode,
  output logic [IO_WIDTH-1:0]  o_core_din,
  output logic                 o_core_din_valid,
  output logic                 o_core_din_last,
  output logic [BITS_W-1:0]    o_core_din_bits,
  input  logic                 i_core_din_ready,
  input  logic [IO_WIDTH-1:0]  i_core_dout,
  input  logic                 i_core_dout_valid,
  output logic                 o_core_dout_ready,
  output logic [IO_WIDTH-1:0]  o_data_out,
  output logic                 o_data_out_valid,
  input  logic                 i_data_out_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int SH = $clog2(IO_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_SQUEEZE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [LEN_WIDTH-1:0]  in_words_q, in_words_d;
  logic [LEN_WIDTH-1:0]  out_words_q, out_words_d;
  logic [SH-1:0]         in_tail_q, in_tail_d;
  logic [SH-1:0]         out_tail_q, out_tail_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [IO_WIDTH-1:0]   skid_mem_q [2];
  logic [IO_WIDTH-1:0]   skid_mem_d [2];
  logic                  skid_wr_q, skid_wr_d;
  logic                  skid_rd_q, skid_rd_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;

  logic                  absorb, squeeze, in_zero, rd_issue, skid_has, beat_avail;
  logic                  beat_last, accept, push, pop, out_last, out_fire;
  logic [1:0]            occ;
  logic [IO_WIDTH-1:0]   beat_raw, in_mask, out_mask;

  assign absorb  = (state_q == S_ABSORB);
  assign squeeze = (state_q == S_SQUEEZE);
  assign in_zero = (in_words_q == '0);

  // Skid occupancy plus the outstanding read bounds storage at two words.
  assign occ      = skid_cnt_q + {1'b0, inflight_q};
  assign rd_issue = absorb && (rd_cnt_q < in_words_q) && (occ < 2'd2);
  assign o_rd_en  = rd_issue;
  assign o_addr   = rd_issue ? base_q + rd_cnt_q[ADDR_W-1:0] : '0;

  // Empty skid bypasses the returning RAM word straight to the core.
  assign skid_has   = (skid_cnt_q != 2'd0);
  assign beat_avail = in_zero || skid_has || inflight_q;
  assign beat_raw   = in_zero ? '0 : (skid_has ? skid_mem_q[skid_rd_q] : i_data_in);
  assign beat_last  = in_zero || (beat_q == in_words_q - LEN_WIDTH'(1));
  assign accept     = o_core_din_valid && i_core_din_ready;
  assign push       = inflight_q && !(accept && !skid_has);
  assign pop        = accept && skid_has;

  always_comb begin
    in_mask  = '0;
    out_mask = '0;
    for (int unsigned i = 0; i < IO_WIDTH; i++) begin
      in_mask[i]  = (in_tail_q == '0)  || (i < 32'(in_tail_q));
      out_mask[i] = (out_tail_q == '0) || (i < 32'(out_tail_q));
    end
  end

  assign o_core_mode      = mode_q;
  assign o_core_din_valid = absorb && beat_avail;
  assign o_core_din_last  = o_core_din_valid && beat_last;
  assign o_core_din       = !o_core_din_valid ? '0 :
                            (beat_last ? (beat_raw & in_mask) : beat_raw);
  assign o_core_din_bits  = (!o_core_din_valid || in_zero) ? '0 :
                            ((beat_last && in_tail_q != '0) ? BITS_W'(in_tail_q)
                                                            : BITS_W'(IO_WIDTH));

  assign out_last          = (out_cnt_q == out_words_q - LEN_WIDTH'(1));
  assign out_fire          = squeeze && i_core_dout_valid && i_data_out_ready;
  assign o_core_dout_ready = squeeze && i_data_out_ready;
  assign o_data_out_valid  = squeeze && i_core_dout_valid;
  assign o_data_out        = !squeeze ? '0 : (out_last ? (i_core_dout & out_mask) : i_core_dout);

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    in_words_d  = in_words_q;
    out_words_d = out_words_q;
    in_tail_d   = in_tail_q;
    out_tail_d  = out_tail_q;
    rd_cnt_d    = rd_cnt_q;
    beat_d      = beat_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = inflight_q;
    skid_mem_d  = skid_mem_q;
    skid_wr_d   = skid_wr_q;
    skid_rd_d   = skid_rd_q;
    skid_cnt_d  = skid_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_ABSORB;
          mode_d      = i_mode;
          base_d      = i_base_addr;
          in_tail_d   = i_input_length[SH-1:0];
          out_tail_d  = i_output_length[SH-1:0];
          in_words_d  = (i_input_length >> SH) + LEN_WIDTH'(|i_input_length[SH-1:0]);
          out_words_d = (i_output_length >> SH) + LEN_WIDTH'(|i_output_length[SH-1:0]);
          rd_cnt_d    = '0;
          beat_d      = '0;
          out_cnt_d   = '0;
          inflight_d  = 1'b0;
          skid_wr_d   = 1'b0;
          skid_rd_d   = 1'b0;
          skid_cnt_d  = '0;
        end
      end
      S_ABSORB: begin
        inflight_d = rd_issue;
        if (rd_issue) rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
        if (push) begin
          skid_mem_d[skid_wr_q] = i_data_in;
          skid_wr_d             = ~skid_wr_q;
        end
        if (pop) skid_rd_d = ~skid_rd_q;
        skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, pop};
        if (accept) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (beat_last) state_d = (out_words_q == '0) ? S_DONE : S_SQUEEZE;
        end
      end
      S_SQUEEZE: begin
        if (out_fire) begin
          out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
          if (out_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      base_q      <= '0;
      in_words_q  <= '0;
      out_words_q <= '0;
      in_tail_q   <= '0;
      out_tail_q  <= '0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      skid_mem_q  <= '{default: '0};
      skid_wr_q   <= 1'b0;
      skid_rd_q   <= 1'b0;
      skid_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      in_words_q  <= in_words_d;
      out_words_q <= out_words_d;
      in_tail_q   <= in_tail_d;
      out_tail_q  <= out_tail_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_q      <= beat_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      skid_mem_q  <= skid_mem_d;
      skid_wr_q   <= skid_wr_d;
      skid_rd_q   <= skid_rd_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

endmodule

// File: tb/tb_hash_mem_stream_if.sv
// Randomised bench for hash_mem_stream_if: RAM, core and consumer models with a
// queue-based reference of the expected read, absorb and squeeze streams.
module tb_hash_mem_stream_if;

  localparam int IO    = 32;
  localparam int DEPTH = 128;
  localparam int LW    = 32;
  localparam int AW    = 7;
  localparam int BW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_mode;
  logic [AW-1:0] i_base_addr;
  logic [LW-1:0] i_input_length, i_output_length;
  logic          o_rd_en;
  logic [AW-1:0] o_addr;
  logic [IO-1:0] i_data_in;
  logic          o_core_mode;
  logic [IO-1:0] o_core_din;
  logic          o_core_din_valid, o_core_din_last;
  logic [BW-1:0] o_core_din_bits;
  logic          i_core_din_ready;
  logic [IO-1:0] i_core_dout;
  logic          i_core_dout_valid, o_core_dout_ready;
  logic [IO-1:0] o_data_out;
  logic          o_data_out_valid, i_data_out_ready;
  logic          o_busy, o_done;

  always #5 clk = ~clk;

  hash_mem_stream_if #(.IO_WIDTH(IO), .MAX_RAM_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_base_addr(i_base_addr), .i_input_length(i_input_length),
    .i_output_length(i_output_length), .o_rd_en(o_rd_en), .o_addr(o_addr),
    .i_data_in(i_data_in), .o_core_mode(o_core_mode), .o_core_din(o_core_din),
    .o_core_din_valid(o_core_din_valid), .o_core_din_last(o_core_din_last),
    .o_core_din_bits(o_core_din_bits), .i_core_din_ready(i_core_din_ready),
    .i_core_dout(i_core_dout), .i_core_dout_valid(i_core_dout_valid),
    .o_core_dout_ready(o_core_dout_ready), .o_data_out(o_data_out),
    .o_data_out_valid(o_data_out_valid), .i_data_out_ready(i_data_out_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct { logic [IO-1:0] d; logic l; logic [BW-1:0] b; } beat_t;

  logic [IO-1:0] mem [DEPTH];
  logic [IO-1:0] dig [64];
  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  int            din_mode = 0, dout_mode = 0, lo_cnt = 0, core_idx = 0;
  int            rd_q[$];
  beat_t         beat_q[$];
  logic [IO-1:0] out_q[$];
  int            done_cnt, hold_viol, addr_viol;
  int            ncyc = 0, start_cyc, first_rd_cyc, first_val_cyc;
  logic          pend;
  beat_t         pb;

  // RAM: registered read, junk on the bus when no read was issued
  always @(posedge clk) begin
    if (o_rd_en) i_data_in <= mem[o_addr];
    else         i_data_in <= $urandom;
  end

  // Core and consumer handshake drivers
  always @(posedge clk) begin
    #1;
    case (din_mode)
      0: i_core_din_ready = 1'b1;
      1: i_core_din_ready = ~i_core_din_ready;
      2: i_core_din_ready = ($urandom_range(0, 2) != 0);
      default: i_core_din_ready = 1'b0;
    endcase
    case (dout_mode)
      0: i_data_out_ready = 1'b1;
      1: i_data_out_ready = ($urandom_range(0, 1) != 0);
      default: begin
        if (out_q.size() == 1 && lo_cnt < 5) begin
          i_data_out_ready = 1'b0;
          lo_cnt++;
        end else i_data_out_ready = 1'b1;
      end
    endcase
    i_core_dout_valid = ($urandom_range(0, 3) != 0);
    i_core_dout       = dig[core_idx % 64];
  end

  // Monitor, sampled mid-cycle
  always @(negedge clk) begin
    beat_t cur;
    ncyc++;
    cur.d = o_core_din; cur.l = o_core_din_last; cur.b = o_core_din_bits;
    if (i_start && !o_busy && start_cyc < 0) start_cyc = ncyc;
    if (o_rd_en) begin
      rd_q.push_back(int'(o_addr));
      if (first_rd_cyc < 0) first_rd_cyc = ncyc;
    end else if (o_addr != '0) addr_viol++;
    if (o_core_din_valid && first_val_cyc < 0) first_val_cyc = ncyc;
    if (pend && (!o_core_din_valid || cur.d !== pb.d || cur.l !== pb.l || cur.b !== pb.b))
      hold_viol++;
    pend = o_core_din_valid && !i_core_din_ready;
    pb   = cur;
    if (o_core_din_valid && i_core_din_ready) beat_q.push_back(cur);
    if (i_core_dout_valid && o_core_dout_ready) core_idx++;
    if (o_data_out_valid && i_data_out_ready) out_q.push_back(o_data_out);
    if (o_done) done_cnt++;
  end

  function automatic logic [IO-1:0] keep_low(input logic [IO-1:0] w, input int n);
    logic [63:0] m;
    if (n == 0) return w;
    m = (64'd1 << n) - 64'd1;
    return w & m[IO-1:0];
  endfunction

  task automatic clear_mon();
    rd_q.delete(); beat_q.delete(); out_q.delete();
    done_cnt = 0; hold_viol = 0; addr_viol = 0; core_idx = 0; lo_cnt = 0;
    start_cyc = -1; first_rd_cyc = -1; first_val_cyc = -1; pend = 1'b0;
    foreach (mem[i]) mem[i] = $urandom;
    foreach (dig[i]) dig[i] = $urandom;
  endtask

  task automatic start_job(input logic mode, input int base, input int in_len,
                           input int out_len, input int hold);
    @(posedge clk); #2;
    i_mode = mode; i_base_addr = AW'(base);
    i_input_length = LW'(in_len); i_output_length = LW'(out_len); i_start = 1'b1;
    repeat (hold) begin @(posedge clk); #2; end
    i_start = 1'b0; i_mode = ~mode; i_base_addr = AW'($urandom);
    i_input_length = $urandom; i_output_length = $urandom;
  endtask

  task automatic run_job(input string nm, input logic mode, input int base, input int in_len,
                         input int out_len, input int dm, input int om, input int hold);
    int iw, it, ow, ot, n;
    beat_t exp_b[$];
    beat_t e;
    clear_mon();
    din_mode = dm; dout_mode = om;
    start_job(mode, base, in_len, out_len, hold);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    iw = (in_len + IO - 1) / IO; it = in_len % IO;
    ow = (out_len + IO - 1) / IO; ot = out_len % IO;
    if (in_len == 0) begin
      e.d = '0; e.l = 1'b1; e.b = '0; exp_b.push_back(e);
    end
    for (int k = 0; k < iw; k++) begin
      e.l = (k == iw - 1);
      e.d = e.l ? keep_low(mem[(base + k) % DEPTH], it) : mem[(base + k) % DEPTH];
      e.b = (e.l && it != 0) ? BW'(it) : BW'(IO);
      exp_b.push_back(e);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt);
    end
    vectors++;
    if (rd_q.size() !== iw) begin
      miscompares++; $display("FAIL %s read_count: got %0d want %0d", nm, rd_q.size(), iw);
    end
    n = (rd_q.size() < iw) ? rd_q.size() : iw;
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (rd_q[k] !== (base + k) % DEPTH) begin
        miscompares++;
        $display("FAIL %s read_addr[%0d]: got %0d want %0d", nm, k, rd_q[k], (base + k) % DEPTH);
      end
    end
    vectors++;
    if (beat_q.size() !== exp_b.size()) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d want %0d", nm, beat_q.size(), exp_b.size());
    end
    n = (beat_q.size() < exp_b.size()) ? beat_q.size() : exp_b.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (beat_q[k].d !== exp_b[k].d || beat_q[k].l !== exp_b[k].l || beat_q[k].b !== exp_b[k].b) begin
        miscompares++;
        $display("FAIL %s beat[%0d]: got %h/%0d/%0d want %h/%0d/%0d", nm, k, beat_q[k].d,
                 beat_q[k].l, beat_q[k].b, exp_b[k].d, exp_b[k].l, exp_b[k].b);
      end
    end
    vectors++;
    if (out_q.size() !== ow) begin
      miscompares++; $display("FAIL %s out_count: got %0d want %0d", nm, out_q.size(), ow);
    end
    n = (out_q.size() < ow) ? out_q.size() : ow;
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (out_q[k] !== ((k == ow - 1) ? keep_low(dig[k], ot) : dig[k])) begin
        miscompares++;
        $display("FAIL %s out[%0d]: got %h want %h", nm, k, out_q[k],
                 (k == ow - 1) ? keep_low(dig[k], ot) : dig[k]);
      end
    end
    vectors++;
    if (hold_viol !== 0 || addr_viol !== 0) begin
      miscompares++;
      $display("FAIL %s protocol: hold_viol %0d addr_viol %0d want 0/0", nm, hold_viol, addr_viol);
    end
    vectors++;
    if (o_busy !== 1'b0 || o_core_mode !== mode) begin
      miscompares++;
      $display("FAIL %s end_state: busy %b mode %b want 0/%b", nm, o_busy, o_core_mode, mode);
    end
  endtask

  task automatic check_quiet(input string nm);
    logic [127:0] got;
    got = {o_rd_en, 25'(o_addr), o_core_mode, o_core_din, o_core_din_valid, o_core_din_last,
           o_core_din_bits, o_core_dout_ready, o_data_out, o_data_out_valid, o_busy, o_done};
    vectors++;
    if (got !== '0) begin
      miscompares++; $display("FAIL %s outputs_zero: got %h want 0", nm, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_base_addr = '0;
    i_input_length = '0; i_output_length = '0; i_core_din_ready = 1'b1;
    i_data_out_ready = 1'b1; i_core_dout_valid = 1'b0; i_core_dout = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset_idle");
  endtask

  task automatic test_basic();
    run_job("basic", 1'b0, 0, 2760, 128, 0, 0, 1);
    vectors++;
    if (first_rd_cyc !== start_cyc + 1 || first_val_cyc !== first_rd_cyc + 1) begin
      miscompares++;
      $display("FAIL latency: start %0d rd %0d val %0d want rd=start+1 val=rd+1",
               start_cyc, first_rd_cyc, first_val_cyc);
    end
  endtask

  task automatic test_backpressure();
    run_job("toggle_ready", 1'b0, 0, 2760, 128, 1, 0, 1);
    run_job("random_ready", 1'b1, 17, 1000, 300, 2, 1, 1);
  endtask

  task automatic test_wrap();
    run_job("no_wrap", 1'b0, 120, 256, 64, 0, 0, 1);
    run_job("wrap", 1'b1, 125, 256, 64, 2, 1, 1);
  endtask

  task automatic test_zero_len();
    run_job("in_zero", 1'b1, 5, 0, 32, 0, 0, 1);
    run_job("out_zero", 1'b0, 3, 64, 0, 1, 0, 1);
  endtask

  task automatic test_out_tail();
    run_job("out_tail_pause", 1'b0, 9, 100, 40, 0, 2, 1);
  endtask

  task automatic test_back_to_back();
    run_job("start_held", 1'b1, 60, 96, 64, 0, 0, 3);
    run_job("b2b", 1'b0, 1, 33, 33, 2, 1, 1);
    for (int r = 0; r < 6; r++)
      run_job("random", 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, 4000)), int'($urandom_range(0, 2048)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1);
  endtask

  task automatic test_mid_reset();
    clear_mon();
    din_mode = 3; dout_mode = 0;
    start_job(1'b1, 0, 2760, 128, 1);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_quiet("mid_absorb_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset_release");
    run_job("clean_after_reset", 1'b0, 0, 2760, 128, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_out_tail();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
